// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: FSM state encoding,
// default datapath widths and the register number that aliases the PC.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 4;
  localparam int WB_CNT_W  = 8;

  // r15 is the program counter; writes to it redirect fetch instead of
  // landing in the register bank.
  localparam logic [3:0] PC_REG = 4'd15;

  typedef enum logic [1:0] {
    WB_IDLE      = 2'd0,
    WB_LOAD_WAIT = 2'd1,
    WB_COMMIT    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_bypass_mux.sv
// Write-through bypass for one register read port: when the bank is being
// written this cycle at the address being read, forward the write data so
// the reader does not see the stale bank value. r15 is never bypassed
// because PC writes do not go to the bank.
// Only built when WB_BYPASS_EN is defined.
`ifdef WB_BYPASS_EN
module wb_bypass_mux
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic [DATA_W-1:0] i_rdata_bank,
  output logic [DATA_W-1:0] o_rdata
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

  logic w_hit;

  assign w_hit   = i_we && (i_waddr == i_raddr) && (i_raddr != PC_ADDR);
  assign o_rdata = w_hit ? i_wdata : i_rdata_bank;

endmodule
`endif

// File: rtl/writeback_stage.sv
// Writeback stage: accepts one retiring instruction per handshake, picks
// the ALU result or load data, and drives the bank write port. Writes to
// r15 become a one-cycle fetch redirect instead of a bank write. Loads
// wait for read data under a bounded timeout; a timeout sets a sticky
// error flag that only reset clears.
// Optional feature macro: WB_BYPASS_EN adds write-through read bypass ports.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_W       = WB_DATA_W,
  parameter int ADDR_W       = WB_ADDR_W,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_alu,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              we3,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3,
  output logic              pc_write,
  output logic [DATA_W-1:0] pc_next,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [DATA_W-1:0] rd1_bank,
  input  logic [DATA_W-1:0] rd2_bank,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
`endif
  output logic              load_err
);

  localparam logic [ADDR_W-1:0]   PC_ADDR     = ADDR_W'(PC_REG);
  localparam logic [WB_CNT_W-1:0] TIMEOUT_CNT = WB_CNT_W'(LOAD_TIMEOUT);

  wb_state_t           r_state;
  logic [ADDR_W-1:0]   r_rd;
  logic [WB_CNT_W-1:0] r_cnt;
  logic                r_load_err;
  logic                r_we3;
  logic [ADDR_W-1:0]   r_a3;
  logic [DATA_W-1:0]   r_wd3;
  logic                r_pc_write;
  logic [DATA_W-1:0]   r_pc_next;

  logic                w_commit;
  logic [ADDR_W-1:0]   w_commit_rd;
  logic [DATA_W-1:0]   w_commit_data;

  // Decide whether the state entered at the next edge is COMMIT, and with
  // which destination and data, so the output registers can load in step.
  always_comb begin
    w_commit      = 1'b0;
    w_commit_rd   = r_rd;
    w_commit_data = mem_rdata;
    case (r_state)
      WB_IDLE: begin
        if (in_valid && in_reg_write && !in_mem_to_reg) begin
          w_commit      = 1'b1;
          w_commit_rd   = in_rd;
          w_commit_data = in_alu;
        end
      end
      WB_LOAD_WAIT: begin
        if (mem_rvalid) begin
          w_commit = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Control FSM: handshake, load wait with timeout counter, one-cycle commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= WB_IDLE;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_load_err <= 1'b0;
    end else begin
      case (r_state)
        WB_IDLE: begin
          if (in_valid) begin
            r_rd  <= in_rd;
            r_cnt <= '0;
            if (!in_reg_write) begin
              r_state <= WB_IDLE;
            end else if (in_mem_to_reg) begin
              r_state <= WB_LOAD_WAIT;
            end else begin
              r_state <= WB_COMMIT;
            end
          end
        end
        WB_LOAD_WAIT: begin
          if (mem_rvalid) begin
            r_state <= WB_COMMIT;
          end else if (r_cnt == TIMEOUT_CNT) begin
            r_load_err <= 1'b1;
            r_state    <= WB_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WB_COMMIT: begin
          r_state <= WB_IDLE;
        end
        default: begin
          r_state <= WB_IDLE;
        end
      endcase
    end
  end

  // Registered write-port and redirect outputs, loaded on entry to COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we3      <= 1'b0;
      r_a3       <= '0;
      r_wd3      <= '0;
      r_pc_write <= 1'b0;
      r_pc_next  <= '0;
    end else begin
      r_we3      <= w_commit && (w_commit_rd != PC_ADDR);
      r_pc_write <= w_commit && (w_commit_rd == PC_ADDR);
      if (w_commit && (w_commit_rd != PC_ADDR)) begin
        r_a3  <= w_commit_rd;
        r_wd3 <= w_commit_data;
      end
      if (w_commit && (w_commit_rd == PC_ADDR)) begin
        r_pc_next <= w_commit_data;
      end
    end
  end

  assign in_ready = (r_state == WB_IDLE);
  assign we3      = r_we3;
  assign a3       = r_a3;
  assign wd3      = r_wd3;
  assign pc_write = r_pc_write;
  assign pc_next  = r_pc_next;
  assign load_err = r_load_err;

`ifdef WB_BYPASS_EN
  wb_bypass_mux #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_bypass_rd1 (
    .i_we        (r_we3),
    .i_waddr     (r_a3),
    .i_wdata     (r_wd3),
    .i_raddr     (ra1),
    .i_rdata_bank(rd1_bank),
    .o_rdata     (rd1)
  );

  wb_bypass_mux #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_bypass_rd2 (
    .i_we        (r_we3),
    .i_waddr     (r_a3),
    .i_wdata     (r_wd3),
    .i_raddr     (ra2),
    .i_rdata_bank(rd2_bank),
    .o_rdata     (rd2)
  );
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage. Each transaction is driven, its
// outputs are recorded over a fixed window as cycle indices (cycle 0 is the
// cycle right after the accepting edge), and each test compares them with
// what the writeback rules predict.
module tb_writeback_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int TO     = 15;
  localparam int WIN    = TO + 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd = '0;
  logic [DATA_W-1:0] in_alu = '0;
  logic              in_reg_write = 1'b0;
  logic              in_mem_to_reg = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_rvalid = 1'b0;
  logic              we3;
  logic [ADDR_W-1:0] a3;
  logic [DATA_W-1:0] wd3;
  logic              pc_write;
  logic [DATA_W-1:0] pc_next;
  logic              load_err;
`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0] ra1 = '0;
  logic [ADDR_W-1:0] ra2 = '0;
  logic [DATA_W-1:0] rd1_bank = '0;
  logic [DATA_W-1:0] rd2_bank = '0;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
`endif

  writeback_stage #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .LOAD_TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_alu       (in_alu),
    .in_reg_write (in_reg_write),
    .in_mem_to_reg(in_mem_to_reg),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .we3          (we3),
    .a3           (a3),
    .wd3          (wd3),
    .pc_write     (pc_write),
    .pc_next      (pc_next),
`ifdef WB_BYPASS_EN
    .ra1          (ra1),
    .ra2          (ra2),
    .rd1_bank     (rd1_bank),
    .rd2_bank     (rd2_bank),
    .rd1          (rd1),
    .rd2          (rd2),
`endif
    .load_err     (load_err)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the bench gets stuck.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the test sequence finished");
    $fatal(1, "[TB] watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Observations from the most recent transaction.
  int              obs_we_cnt, obs_we_cyc, obs_pc_cnt, obs_pc_cyc;
  int              obs_err_cyc, obs_ready_cyc;
  logic [ADDR_W-1:0] obs_a3;
  logic [DATA_W-1:0] obs_wd3, obs_pc_next;

  // Reference-model sticky error flag.
  bit model_err = 1'b0;

  // Drive one instruction and record what the stage does over WIN cycles.
  // dly is the cycle index in which mem_rvalid is pulsed (-1: never).
  task automatic run_txn(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] alu,
                         input logic rw, input logic m2r, input int dly,
                         input logic [DATA_W-1:0] rdata);
    logic prev_err;
    @(negedge clk);
    in_valid = 1'b1; in_rd = rd; in_alu = alu;
    in_reg_write = rw; in_mem_to_reg = m2r; mem_rvalid = 1'b0;
    obs_we_cnt = 0; obs_we_cyc = -1; obs_pc_cnt = 0; obs_pc_cyc = -1;
    obs_err_cyc = -1; obs_ready_cyc = -1;
    obs_a3 = '0; obs_wd3 = '0; obs_pc_next = '0;
    prev_err = load_err;
    @(posedge clk);
    for (int cyc = 0; cyc <= WIN; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        in_valid = 1'b0;
        in_rd = 4'($urandom_range(0, 15));
        in_alu = $urandom;
        in_reg_write = 1'($urandom_range(0, 1));
        in_mem_to_reg = 1'($urandom_range(0, 1));
      end
      if (we3) begin
        obs_we_cnt++;
        if (obs_we_cyc < 0) begin obs_we_cyc = cyc; obs_a3 = a3; obs_wd3 = wd3; end
      end
      if (pc_write) begin
        obs_pc_cnt++;
        if (obs_pc_cyc < 0) begin obs_pc_cyc = cyc; obs_pc_next = pc_next; end
      end
      if (load_err && !prev_err && obs_err_cyc < 0) obs_err_cyc = cyc;
      prev_err = load_err;
      if (in_ready && obs_ready_cyc < 0) obs_ready_cyc = cyc;
      mem_rvalid = (cyc == dly);
      mem_rdata  = (cyc == dly) ? rdata : $urandom;
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (we3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_we3 got %b want 0", we3); end
    checks++; if (pc_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_pc_write got %b want 0", pc_write); end
    checks++; if (a3 !== '0) begin errors++; $display("[TB] FAIL reset_a3 got %0h want 0", a3); end
    checks++; if (wd3 !== '0) begin errors++; $display("[TB] FAIL reset_wd3 got %0h want 0", wd3); end
    checks++; if (pc_next !== '0) begin errors++; $display("[TB] FAIL reset_pc_next got %0h want 0", pc_next); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_err got %b want 0", load_err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_err = 1'b0;
  endtask

  task automatic test_alu_write();
    run_txn(4'd3, 32'h12345678, 1'b1, 1'b0, -1, 32'h0);
    checks++; if (obs_we_cyc !== 0) begin errors++; $display("[TB] FAIL alu_we_cycle got %0d want 0", obs_we_cyc); end
    checks++; if (obs_we_cnt !== 1) begin errors++; $display("[TB] FAIL alu_we_pulses got %0d want 1", obs_we_cnt); end
    checks++; if (obs_a3 !== 4'd3) begin errors++; $display("[TB] FAIL alu_a3 got %0d want 3", obs_a3); end
    checks++; if (obs_wd3 !== 32'h12345678) begin errors++; $display("[TB] FAIL alu_wd3 got %h want 12345678", obs_wd3); end
    checks++; if (obs_ready_cyc !== 1) begin errors++; $display("[TB] FAIL alu_ready_cycle got %0d want 1", obs_ready_cyc); end
    checks++; if (obs_pc_cnt !== 0) begin errors++; $display("[TB] FAIL alu_pc_pulses got %0d want 0", obs_pc_cnt); end
  endtask

  task automatic test_load();
    run_txn(4'd5, $urandom, 1'b1, 1'b1, 4, 32'hDEADBEEF);
    checks++; if (obs_we_cyc !== 5) begin errors++; $display("[TB] FAIL load_we_cycle got %0d want 5", obs_we_cyc); end
    checks++; if (obs_we_cnt !== 1) begin errors++; $display("[TB] FAIL load_we_pulses got %0d want 1", obs_we_cnt); end
    checks++; if (obs_a3 !== 4'd5) begin errors++; $display("[TB] FAIL load_a3 got %0d want 5", obs_a3); end
    checks++; if (obs_wd3 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL load_wd3 got %h want deadbeef", obs_wd3); end
    checks++; if (obs_ready_cyc !== 6) begin errors++; $display("[TB] FAIL load_ready_cycle got %0d want 6", obs_ready_cyc); end
  endtask

  task automatic test_pc_write();
    run_txn(4'd15, 32'h00000100, 1'b1, 1'b0, -1, 32'h0);
    checks++; if (obs_pc_cyc !== 0) begin errors++; $display("[TB] FAIL pc_cycle got %0d want 0", obs_pc_cyc); end
    checks++; if (obs_pc_cnt !== 1) begin errors++; $display("[TB] FAIL pc_pulses got %0d want 1", obs_pc_cnt); end
    checks++; if (obs_pc_next !== 32'h100) begin errors++; $display("[TB] FAIL pc_next got %h want 00000100", obs_pc_next); end
    checks++; if (obs_we_cnt !== 0) begin errors++; $display("[TB] FAIL pc_we_pulses got %0d want 0", obs_we_cnt); end
  endtask

  task automatic test_no_write();
    run_txn(4'd9, $urandom, 1'b0, 1'b0, 2, $urandom);
    checks++; if (obs_we_cnt !== 0) begin errors++; $display("[TB] FAIL nowrite_we_pulses got %0d want 0", obs_we_cnt); end
    checks++; if (obs_pc_cnt !== 0) begin errors++; $display("[TB] FAIL nowrite_pc_pulses got %0d want 0", obs_pc_cnt); end
    checks++; if (obs_ready_cyc !== 0) begin errors++; $display("[TB] FAIL nowrite_ready_cycle got %0d want 0", obs_ready_cyc); end
  endtask

  task automatic test_timeout();
    run_txn(4'd6, $urandom, 1'b1, 1'b1, -1, 32'h0);
    model_err = 1'b1;
    checks++; if (obs_err_cyc !== TO + 1) begin errors++; $display("[TB] FAIL timeout_err_cycle got %0d want %0d", obs_err_cyc, TO + 1); end
    checks++; if (obs_we_cnt !== 0) begin errors++; $display("[TB] FAIL timeout_we_pulses got %0d want 0", obs_we_cnt); end
    checks++; if (obs_ready_cyc !== TO + 1) begin errors++; $display("[TB] FAIL timeout_ready_cycle got %0d want %0d", obs_ready_cyc, TO + 1); end
    checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_load_err got %b want 1", load_err); end
  endtask

  // Read data arriving in the very last waiting cycle still commits.
  task automatic test_load_boundary();
    run_txn(4'd2, $urandom, 1'b1, 1'b1, TO, 32'hCAFEF00D);
    checks++; if (obs_we_cyc !== TO + 1) begin errors++; $display("[TB] FAIL boundary_we_cycle got %0d want %0d", obs_we_cyc, TO + 1); end
    checks++; if (obs_wd3 !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL boundary_wd3 got %h want cafef00d", obs_wd3); end
    checks++; if (obs_err_cyc !== -1) begin errors++; $display("[TB] FAIL boundary_err_edge got %0d want -1", obs_err_cyc); end
  endtask

  task automatic test_err_sticky();
    run_txn(4'd8, 32'h0BADC0DE, 1'b1, 1'b0, -1, 32'h0);
    checks++; if (obs_we_cnt !== 1) begin errors++; $display("[TB] FAIL sticky_we_pulses got %0d want 1", obs_we_cnt); end
    checks++; if (obs_wd3 !== 32'h0BADC0DE) begin errors++; $display("[TB] FAIL sticky_wd3 got %h want 0badc0de", obs_wd3); end
    checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL sticky_load_err got %b want 1", load_err); end
  endtask

  task automatic test_reset_mid_load();
    int we_seen = 0;
    int not_ready = 0;
    @(negedge clk);
    in_valid = 1'b1; in_rd = 4'd4; in_reg_write = 1'b1; in_mem_to_reg = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready got %b want 1", in_ready); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_load_err got %b want 0", load_err); end
    @(negedge clk);
    rst_n = 1'b1;
    model_err = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (we3) we_seen++;
      if (!in_ready) not_ready++;
      @(negedge clk);
    end
    checks++; if (we_seen !== 0) begin errors++; $display("[TB] FAIL midrst_we_pulses got %0d want 0", we_seen); end
    checks++; if (not_ready !== 0) begin errors++; $display("[TB] FAIL midrst_busy_cycles got %0d want 0", not_ready); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_load_err_after got %b want 0", load_err); end
  endtask

  // Random instruction mix checked against the writeback rules.
  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] alu, rdata, exp_data;
      logic rw, m2r;
      int dly, commit, exp_ready, exp_err_cyc;
      bit timeout;
      rd    = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      alu   = $urandom;
      rdata = $urandom;
      rw    = ($urandom_range(0, 5) != 0);
      m2r   = 1'($urandom_range(0, 1));
      dly   = ($urandom_range(0, 6) == 0) ? -1 : int'($urandom_range(0, TO + 3));
      commit = -1; exp_data = '0; timeout = 1'b0; exp_ready = 0; exp_err_cyc = -1;
      if (!rw) exp_ready = 0;
      else if (!m2r) begin commit = 0; exp_data = alu; end
      else if (dly >= 0 && dly <= TO) begin commit = dly + 1; exp_data = rdata; end
      else timeout = 1'b1;
      if (commit >= 0) exp_ready = commit + 1;
      if (timeout) begin
        exp_ready = TO + 1;
        if (!model_err) exp_err_cyc = TO + 1;
        model_err = 1'b1;
      end
      run_txn(rd, alu, rw, m2r, dly, rdata);
      if (commit >= 0 && rd != 4'd15) begin
        checks++; if (obs_we_cnt !== 1 || obs_we_cyc !== commit) begin errors++; $display("[TB] FAIL rnd%0d_we got cnt %0d cyc %0d want cnt 1 cyc %0d", t, obs_we_cnt, obs_we_cyc, commit); end
        checks++; if (obs_a3 !== rd || obs_wd3 !== exp_data) begin errors++; $display("[TB] FAIL rnd%0d_wdata got a3 %0d wd3 %h want a3 %0d wd3 %h", t, obs_a3, obs_wd3, rd, exp_data); end
        checks++; if (obs_pc_cnt !== 0) begin errors++; $display("[TB] FAIL rnd%0d_pc_pulses got %0d want 0", t, obs_pc_cnt); end
      end else if (commit >= 0) begin
        checks++; if (obs_pc_cnt !== 1 || obs_pc_cyc !== commit) begin errors++; $display("[TB] FAIL rnd%0d_pc got cnt %0d cyc %0d want cnt 1 cyc %0d", t, obs_pc_cnt, obs_pc_cyc, commit); end
        checks++; if (obs_pc_next !== exp_data) begin errors++; $display("[TB] FAIL rnd%0d_pc_next got %h want %h", t, obs_pc_next, exp_data); end
        checks++; if (obs_we_cnt !== 0) begin errors++; $display("[TB] FAIL rnd%0d_we_pulses got %0d want 0", t, obs_we_cnt); end
      end else begin
        checks++; if (obs_we_cnt !== 0 || obs_pc_cnt !== 0) begin errors++; $display("[TB] FAIL rnd%0d_nocommit got we %0d pc %0d want 0 0", t, obs_we_cnt, obs_pc_cnt); end
      end
      checks++; if (obs_ready_cyc !== exp_ready) begin errors++; $display("[TB] FAIL rnd%0d_ready_cycle got %0d want %0d", t, obs_ready_cyc, exp_ready); end
      checks++; if (obs_err_cyc !== exp_err_cyc) begin errors++; $display("[TB] FAIL rnd%0d_err_edge got %0d want %0d", t, obs_err_cyc, exp_err_cyc); end
      checks++; if (load_err !== model_err) begin errors++; $display("[TB] FAIL rnd%0d_load_err got %b want %b", t, load_err, model_err); end
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    ra1 = 4'd7; ra2 = 4'd15; rd1_bank = 32'h11; rd2_bank = 32'h22;
    @(negedge clk);
    in_valid = 1'b1; in_rd = 4'd7; in_alu = 32'hAA; in_reg_write = 1'b1; in_mem_to_reg = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (rd1 !== 32'hAA) begin errors++; $display("[TB] FAIL bypass_rd1 got %h want aa", rd1); end
    checks++; if (rd2 !== 32'h22) begin errors++; $display("[TB] FAIL bypass_rd2 got %h want 22", rd2); end
    @(negedge clk);
    checks++; if (rd1 !== 32'h11) begin errors++; $display("[TB] FAIL bypass_rd1_after got %h want 11", rd1); end
  endtask
`endif

  initial begin
    $display("[TB] writeback_stage bench start");
    test_reset();
    test_alu_write();
    test_load();
    test_pc_write();
    test_no_write();
    test_timeout();
    test_load_boundary();
    test_err_sticky();
    test_random(30);
    test_reset_mid_load();
    test_random(20);
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
